alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial controller driving an external 1-bit ALU slice, LSB first.
// Optional macro ALU_SERIAL_OVF_EN: signed overflow flag and signed SLT.
module alu_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       AluCtrl,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceCIN,
  output logic             SliceAInvert,
  output logic             SliceBInvert,
  output logic             SliceLess,
  output logic [2:0]       SliceOp,
  input  logic             SliceResult,
  input  logic             SliceCarryOut,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LESS,
    S_DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [IW-1:0]    idx;
  logic             cr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ainv_q;
  logic             binv_q;
  logic [2:0]       op_q;
  logic             s_q;
  logic [WIDTH-1:0] res_nxt;
  logic             last;
  logic             legal;
  logic             arith;
  logic             init_c;
  logic             ovf_c;
  logic             sign_c;

  assign last   = (idx == LAST);
  assign legal  = (AluCtrl[2:0] <= OP_SLT);
  assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign init_c = (op_q == OP_SUB) || (op_q == OP_SLT) || binv_q;

  // carry into the MSB differs from carry out on signed overflow
`ifdef ALU_SERIAL_OVF_EN
  assign ovf_c = SliceCIN ^ SliceCarryOut;
`else
  assign ovf_c = 1'b0;
`endif
  assign sign_c = SliceResult ^ ovf_c;

  // result with the current slice bit merged in
  always_comb begin
    res_nxt      = Result;
    res_nxt[idx] = SliceResult;
  end

  // state register
  always_ff @(posedge Clock) begin
    if (!ResetN) state <= S_IDLE;
    else         state <= nxt;
  end

  // next state and slice drive
  always_comb begin
    nxt          = state;
    SliceA       = 1'b0;
    SliceB       = 1'b0;
    SliceCIN     = 1'b0;
    SliceAInvert = 1'b0;
    SliceBInvert = 1'b0;
    SliceLess    = 1'b0;
    SliceOp      = OP_AND;
    Busy         = 1'b0;
    Done         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) nxt = legal ? S_RUN : S_DONE;
      end
      S_RUN: begin
        Busy         = 1'b1;
        SliceA       = a_q[idx];
        SliceB       = b_q[idx];
        SliceCIN     = (idx == '0) ? init_c : cr;
        SliceAInvert = ainv_q;
        SliceBInvert = binv_q;
        SliceOp      = (op_q == OP_SLT) ? OP_SUB : op_q;
        if (last) nxt = (op_q == OP_SLT) ? S_LESS : S_DONE;
      end
      S_LESS: begin
        Busy      = 1'b1;
        SliceOp   = OP_SLT;
        SliceLess = (idx == '0) ? s_q : 1'b0;
        if (last) nxt = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        nxt  = S_IDLE;
      end
    endcase
  end

  // operand capture, result assembly and flags
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      idx      <= '0;
      cr       <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      op_q     <= OP_AND;
      s_q      <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (Start) begin
            a_q      <= OpA;
            b_q      <= OpB;
            ainv_q   <= AluCtrl[4];
            binv_q   <= AluCtrl[3];
            op_q     <= AluCtrl[2:0];
            idx      <= '0;
            cr       <= 1'b0;
            s_q      <= 1'b0;
            Result   <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Illegal  <= !legal;
            Zero     <= !legal;
          end
        end
        S_RUN: begin
          cr     <= SliceCarryOut;
          Result <= res_nxt;
          idx    <= last ? '0 : idx + IW'(1);
          if (last) begin
            CarryOut <= SliceCarryOut;
            Overflow <= arith & ovf_c;
            s_q      <= sign_c;
            Zero     <= (res_nxt == '0);
          end
        end
        S_LESS: begin
          Result <= res_nxt;
          idx    <= last ? '0 : idx + IW'(1);
          if (last) Zero <= (res_nxt == '0);
        end
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a behavioural 1-bit slice.
// Word-level reference model; honours ALU_SERIAL_OVF_EN when defined.
module tb_alu_serial_ctrl;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [4:0]  AluCtrl;
  logic        SliceA;
  logic        SliceB;
  logic        SliceCIN;
  logic        SliceAInvert;
  logic        SliceBInvert;
  logic        SliceLess;
  logic [2:0]  SliceOp;
  logic        SliceResult;
  logic        SliceCarryOut;
  logic        Busy;
  logic        Done;
  logic [15:0] Result;
  logic        CarryOut;
  logic        Zero;
  logic        Overflow;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_res;
  logic        exp_co;
  logic        exp_ov;
  logic        exp_il;
  logic        exp_z;
  int          exp_lat;
  int          last_lat;

`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  alu_serial_ctrl #(.WIDTH(16)) dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .Start        (Start),
    .OpA          (OpA),
    .OpB          (OpB),
    .AluCtrl      (AluCtrl),
    .SliceA       (SliceA),
    .SliceB       (SliceB),
    .SliceCIN     (SliceCIN),
    .SliceAInvert (SliceAInvert),
    .SliceBInvert (SliceBInvert),
    .SliceLess    (SliceLess),
    .SliceOp      (SliceOp),
    .SliceResult  (SliceResult),
    .SliceCarryOut(SliceCarryOut),
    .Busy         (Busy),
    .Done         (Done),
    .Result       (Result),
    .CarryOut     (CarryOut),
    .Zero         (Zero),
    .Overflow     (Overflow),
    .Illegal      (Illegal)
  );

  always #5 Clock = ~Clock;

  // behavioural 1-bit ALU slice; op 001 inverts B internally
  logic sa;
  logic sb;
  always_comb begin
    sa = SliceA ^ SliceAInvert;
    sb = SliceB ^ SliceBInvert ^ (SliceOp == 3'b001);
    SliceCarryOut = (sa & sb) | (sa & SliceCIN) | (sb & SliceCIN);
    SliceResult = 1'b0;
    case (SliceOp)
      3'b000: SliceResult = sa & sb;
      3'b010: SliceResult = sa | sb;
      3'b011: SliceResult = sa ^ sb;
      3'b001: SliceResult = sa ^ sb ^ SliceCIN;
      3'b100: SliceResult = sa ^ sb ^ SliceCIN;
      3'b101: SliceResult = SliceLess;
      default: SliceResult = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // word-level reference
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] c);
    logic [15:0] ai, bi, bx;
    logic [16:0] s;
    logic        sub, cin, vraw, vm;
    logic [2:0]  op;
    op   = c[2:0];
    ai   = a ^ {16{c[4]}};
    bi   = b ^ {16{c[3]}};
    sub  = (op == 3'd1) || (op == 3'd5);
    bx   = sub ? ~bi : bi;
    cin  = sub ? 1'b1 : c[3];
    s    = {1'b0, ai} + {1'b0, bx} + {16'd0, cin};
    vraw = (ai[15] == bx[15]) && (s[15] != ai[15]);
    vm   = OVF & vraw;
    exp_co  = s[16];
    exp_ov  = ((op == 3'd1) || (op == 3'd4)) & vm;
    exp_il  = 1'b0;
    exp_lat = 17;
    case (op)
      3'd0: exp_res = ai & bi;
      3'd1: exp_res = s[15:0];
      3'd2: exp_res = ai | bi;
      3'd3: exp_res = ai ^ bi;
      3'd4: exp_res = s[15:0];
      3'd5: begin
        exp_res = {15'd0, s[15] ^ vm};
        exp_lat = 33;
      end
      default: begin
        exp_res = 16'd0;
        exp_co  = 1'b0;
        exp_ov  = 1'b0;
        exp_il  = 1'b1;
        exp_lat = 1;
      end
    endcase
    exp_z = (exp_res == 16'd0);
  endtask

  // compare process: result and flags whenever Done is high
  always @(negedge Clock) begin
    if (ResetN && Done) begin
      chk("result", 32'(Result), 32'(exp_res));
      chk("carryout", 32'(CarryOut), 32'(exp_co));
      chk("zero", 32'(Zero), 32'(exp_z));
      chk("overflow", 32'(Overflow), 32'(exp_ov));
      chk("illegal", 32'(Illegal), 32'(exp_il));
      chk("busy_in_done", 32'(Busy), 32'd0);
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] c, input int pulse_at);
    int first;
    int cnt;
    model(a, b, c);
    @(negedge Clock);
    ResetN  = 1'b1;
    OpA     = a;
    OpB     = b;
    AluCtrl = c;
    Start   = 1'b1;
    first   = 0;
    cnt     = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge Clock);
      if (n == 1) Start = 1'b0;
      if (n == pulse_at) Start = 1'b1;
      if (n == pulse_at + 1) Start = 1'b0;
      if (Done) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    last_lat = first;
    chk("latency", 32'(first), 32'(exp_lat));
    chk("done_count", 32'(cnt), 32'd1);
  endtask

  function automatic logic [31:0] all_out();
    return 32'({Busy, Done, Result, CarryOut, Zero, Overflow,
                Illegal, SliceA, SliceB, SliceCIN, SliceAInvert,
                SliceBInvert, SliceLess, SliceOp});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    ResetN  = 1'b0;
    Start   = 1'b0;
    OpA     = 16'd0;
    OpB     = 16'd0;
    AluCtrl = 5'd0;
    repeat (2) @(negedge Clock);
    chk("reset_outputs", all_out(), 32'd0);

    run_op(16'h7FFF, 16'h0001, 5'b00100, 0);
    chk("add_res", 32'(Result), 32'h8000);
    chk("add_co", 32'(CarryOut), 32'd0);
    chk("add_ovf", 32'(Overflow), 32'(OVF));
    chk("add_lat", 32'(last_lat), 32'd17);

    run_op(16'h0005, 16'h0005, 5'b00001, 0);
    chk("sub_res", 32'(Result), 32'h0000);
    chk("sub_zero", 32'(Zero), 32'd1);
    chk("sub_co", 32'(CarryOut), 32'd1);

    run_op(16'hFFFF, 16'h0001, 5'b00101, 0);
    chk("slt1_res", 32'(Result), 32'h0001);
    chk("slt1_lat", 32'(last_lat), 32'd33);

    run_op(16'h8000, 16'h0001, 5'b00101, 0);
    chk("slt2_res", 32'(Result), OVF ? 32'h0001 : 32'h0000);

    run_op(16'hA5A5, 16'hFFFF, 5'b00011, 5);
    chk("xor_res", 32'(Result), 32'h5A5A);

    run_op(16'h1234, 16'h5678, 5'b00110, 0);
    chk("ill_lat", 32'(last_lat), 32'd1);
    chk("ill_flag", 32'(Illegal), 32'd1);
    chk("ill_res", 32'(Result), 32'h0000);

    run_op(16'hF0F0, 16'h3C3C, 5'b00000, 0);
    run_op(16'h1200, 16'h0034, 5'b00010, 0);
    run_op(16'hF0F0, 16'h0F00, 5'b11000, 0);
    run_op(16'h0010, 16'h0003, 5'b01100, 0);
    run_op(16'h0003, 16'h0005, 5'b00001, 0);
    run_op(16'h0001, 16'h8000, 5'b00101, 0);
    run_op(16'hFFFF, 16'h0001, 5'b00100, 0);
    run_op(16'h8000, 16'h8000, 5'b00100, 0);
    run_op(16'h0000, 16'h0000, 5'b00111, 0);

    // abort an ADD mid-run with reset
    @(negedge Clock);
    OpA     = 16'h1234;
    OpB     = 16'h1111;
    AluCtrl = 5'b00100;
    Start   = 1'b1;
    cnt     = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clock);
      if (n == 1) Start = 1'b0;
      if (n == 8) begin
        chk("busy_before_rst", 32'(Busy), 32'd1);
        ResetN = 1'b0;
      end
      if (n == 9) begin
        chk("abort_outputs", all_out(), 32'd0);
        ResetN = 1'b1;
      end
      if (Done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);

    run_op(16'h1234, 16'h1111, 5'b00100, 0);
    chk("recover_res", 32'(Result), 32'h2345);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
